// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: elastic FIFO between pipeline stages under a valid/ready
// handshake. Stall appears as backpressure (in_ready low), squash as flush.
// There is no explicit FSM. Occupancy (count) encodes EMPTY / PARTIAL / FULL.
// in_ready and out_valid depend only on registered count, so there is no
// combinational path from out_ready to in_ready.
// Optional feature: define PIPE_STALL_CNT_EN to add the 16-bit stall_cnt
// performance counter.
module pipe_stage_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
`ifdef PIPE_STALL_CNT_EN
  output logic [15:0]                stall_cnt,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // A full buffer refuses a push even if the head leaves in the same cycle.
  assign in_ready  = (count != CW'(DEPTH)) & ~RST;
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage write. The array is not reset, and a push during a flush is dropped.
  always_ff @(posedge CLK) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers and occupancy. Priority is RST, then flush, then push/pop.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

`ifdef PIPE_STALL_CNT_EN
  // Saturating count of downstream stall cycles. Only reset clears it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
